// File: rtl/weight_buffer_loader.sv
// Weight buffer loader: takes a (start row, row count) command, then turns each
// accepted 256-bit DDR beat into one registered bank-group write for the weight buffer.
module weight_buffer_loader #(
  parameter int X_PE           = 16,
  parameter int X_MESH         = 16,
  parameter int ADDR_LEN       = 16,
  parameter int DATA_LEN       = 64,
  parameter int DDR_DATA_LEN   = 256,
  parameter int BUFFER_NUM     = 8 * X_PE * X_MESH / DATA_LEN,
  parameter int BANKS_PER_BEAT = DDR_DATA_LEN / DATA_LEN,
  parameter int GROUP_NUM      = BUFFER_NUM / BANKS_PER_BEAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ADDR_LEN-1:0]     cfg_st_addr,
  input  logic [ADDR_LEN:0]       cfg_rows,
  input  logic                    abort,
  input  logic [DDR_DATA_LEN-1:0] ddr_data,
  input  logic                    ddr_valid,
  output logic                    ddr_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    busy,
  output logic                    done
);

  localparam int GW = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUP_NUM - 1);
  localparam logic [BUFFER_NUM-1:0] GRP_MASK =
    {{(BUFFER_NUM - BANKS_PER_BEAT){1'b0}}, {BANKS_PER_BEAT{1'b1}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [ADDR_LEN-1:0]     row_addr_q, row_addr_d;
  logic [ADDR_LEN:0]       rows_left_q, rows_left_d;
  logic [DDR_DATA_LEN-1:0] data_wr_q, data_wr_d;
  logic [ADDR_LEN-1:0]     wr_addr_q, wr_addr_d;
  logic [BUFFER_NUM-1:0]   wr_en_q, wr_en_d;
  logic                    done_q, done_d;

  // Handshake readiness is a pure function of state; abort blocks beat acceptance.
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == LOAD);
  assign ddr_ready = (state_q == LOAD) && !abort;
  assign data_wr   = data_wr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_en     = wr_en_q;
  assign done      = done_q;

  // Next-state, counter and write-port computation.
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    row_addr_d  = row_addr_q;
    rows_left_d = rows_left_q;
    data_wr_d   = data_wr_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = '0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid && !abort) begin
          if (cfg_rows == '0) begin
            done_d = 1'b1;
          end else begin
            row_addr_d  = cfg_st_addr;
            rows_left_d = cfg_rows;
            grp_d       = '0;
            state_d     = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          grp_d   = '0;
        end else if (ddr_valid) begin
          data_wr_d = ddr_data;
          wr_addr_d = row_addr_q;
          wr_en_d   = GRP_MASK << (grp_q * BANKS_PER_BEAT);
          if (grp_q == GRP_LAST) begin
            // Row complete: wrap the group and step to the next row (address wraps silently).
            grp_d       = '0;
            row_addr_d  = row_addr_q + ADDR_LEN'(1);
            rows_left_d = rows_left_q - (ADDR_LEN + 1)'(1);
            if (rows_left_q == (ADDR_LEN + 1)'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end else begin
          grp_d = grp_q;
        end
      end
      default: begin
        state_d = IDLE;
        grp_d   = '0;
      end
    endcase
  end

  // State, counters and registered write port; reset clears write enables at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      row_addr_q  <= '0;
      rows_left_q <= '0;
      data_wr_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      row_addr_q  <= row_addr_d;
      rows_left_q <= rows_left_d;
      data_wr_q   <= data_wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Bench for weight_buffer_loader: a beat-count reference model (row = base + k/8,
// group = k%8) is compared every cycle, plus directed scenarios with literal expectations.
module tb_weight_buffer_loader;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [15:0]  cfg_st_addr;
  logic [16:0]  cfg_rows;
  logic         abort;
  logic [255:0] ddr_data;
  logic         ddr_valid;
  logic         ddr_ready;
  logic [255:0] data_wr;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_en;
  logic         busy;
  logic         done;

  weight_buffer_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_st_addr (cfg_st_addr),
    .cfg_rows    (cfg_rows),
    .abort       (abort),
    .ddr_data    (ddr_data),
    .ddr_valid   (ddr_valid),
    .ddr_ready   (ddr_ready),
    .data_wr     (data_wr),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a load is "base row, row count, beats accepted so far".
  bit           m_active;
  int           m_base;
  int           m_rows;
  int           m_k;
  logic [31:0]  exp_wr_en;
  logic [255:0] exp_data;
  logic [15:0]  exp_addr;
  logic         exp_done;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_active  = 1'b0;
    m_base    = 0;
    m_rows    = 0;
    m_k       = 0;
    exp_wr_en = 32'd0;
    exp_data  = 256'd0;
    exp_addr  = 16'd0;
    exp_done  = 1'b0;
  endtask

  // One clock: drive at negedge, check handshakes, advance model, check registered outputs.
  task automatic cycle(input logic cv, input logic [15:0] st, input logic [16:0] rows,
                       input logic ab, input logic dv, input logic [255:0] d);
    bit was_active;
    bit c_acc;
    bit b_acc;
    @(negedge clk);
    cfg_valid   = cv;
    cfg_st_addr = st;
    cfg_rows    = rows;
    abort       = ab;
    ddr_valid   = dv;
    ddr_data    = d;
    #1;
    was_active = m_active;
    chk("cfg_ready", cfg_ready, !was_active);
    chk("ddr_ready", ddr_ready, was_active && !ab);
    chk("busy", busy, was_active);
    c_acc     = !was_active && cv && !ab;
    b_acc     = was_active && !ab && dv;
    exp_wr_en = 32'd0;
    exp_done  = 1'b0;
    if (b_acc) begin
      exp_wr_en = 32'hF << (4 * (m_k % 8));
      exp_data  = d;
      exp_addr  = 16'(m_base + m_k / 8);
      m_k++;
      if (m_k == m_rows * 8) begin
        m_active = 1'b0;
        exp_done = 1'b1;
      end
    end
    if (c_acc) begin
      if (rows == 17'd0) begin
        exp_done = 1'b1;
      end else begin
        m_active = 1'b1;
        m_base   = int'(st);
        m_rows   = int'(rows);
        m_k      = 0;
      end
    end
    if (was_active && ab) m_active = 1'b0;
    @(posedge clk);
    #1;
    chk("wr_en", wr_en, exp_wr_en);
    chk("data_wr", data_wr, exp_data);
    chk("wr_addr", wr_addr, exp_addr);
    chk("done", done, exp_done);
  endtask

  task automatic beat(input logic [255:0] d);
    cycle(1'b0, 16'd0, 17'd0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    cycle(1'b0, 16'd0, 17'd0, 1'b0, 1'b0, 256'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 256'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_ddr_ready", ddr_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int pat [10];
    logic [255:0] rd;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_st_addr = 16'd0;
    cfg_rows    = 17'd0;
    abort       = 1'b0;
    ddr_valid   = 1'b0;
    ddr_data    = 256'd0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("init_wr_en", wr_en, 256'd0);
    chk("init_data_wr", data_wr, 256'd0);
    chk("init_cfg_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    idle();

    // Two rows at 0x0010, no stalls.
    cycle(1'b1, 16'h0010, 17'd2, 1'b0, 1'b0, 256'd0);
    for (int i = 0; i < 16; i++) begin
      beat(256'(i));
      if (i == 0) begin
        chk("t1_en0", wr_en, 32'h0000000F);
        chk("t1_addr0", wr_addr, 16'h0010);
      end
      if (i == 7) chk("t1_en7", wr_en, 32'hF0000000);
      if (i == 8) chk("t1_addr8", wr_addr, 16'h0011);
      if (i == 15) begin
        chk("t1_done", done, 1'b1);
        chk("t1_cfg_ready", cfg_ready, 1'b1);
      end
    end
    idle();

    // Backpressure: valid pattern 1,0,0,1 then steady.
    pat = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    cnt = 0;
    cycle(1'b1, 16'h0020, 17'd1, 1'b0, 1'b0, 256'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'd0, 17'd0, 1'b0, pat[i] != 0, 256'(i + 100));
      if (wr_en != 32'd0) cnt++;
    end
    chk("t2_write_count", 256'(cnt), 256'd8);
    idle();

    // Row address wrap.
    cycle(1'b1, 16'hFFFF, 17'd2, 1'b0, 1'b0, 256'd0);
    for (int i = 0; i < 16; i++) begin
      beat(256'(i + 200));
      if (i == 7) chk("t3_addr_ffff", wr_addr, 16'hFFFF);
      if (i == 8) chk("t3_addr_0000", wr_addr, 16'h0000);
      if (i == 15) chk("t3_done", done, 1'b1);
    end

    // Zero-row command, then back-to-back command in the done cycle.
    cycle(1'b1, 16'h1234, 17'd0, 1'b0, 1'b1, 256'd7);
    chk("t4_zero_done", done, 1'b1);
    chk("t4_zero_wr_en", wr_en, 256'd0);
    cycle(1'b1, 16'h0040, 17'd1, 1'b0, 1'b0, 256'd0);
    for (int i = 0; i < 8; i++) beat(256'(i + 300));
    chk("t4_done", done, 1'b1);

    // Abort after 3 beats, then a fresh load starts from group 0.
    cycle(1'b1, 16'h0080, 17'd1, 1'b0, 1'b0, 256'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      beat(256'(i + 400));
      if (wr_en != 32'd0) cnt++;
    end
    cycle(1'b0, 16'd0, 17'd0, 1'b1, 1'b1, 256'd999);
    chk("t5_abort_no_done", done, 1'b0);
    chk("t5_cfg_ready", cfg_ready, 1'b1);
    chk("t5_write_count", 256'(cnt), 256'd3);
    cycle(1'b1, 16'h0090, 17'd1, 1'b0, 1'b0, 256'd0);
    beat(256'd500);
    chk("t5_restart_en", wr_en, 32'h0000000F);
    chk("t5_restart_addr", wr_addr, 16'h0090);
    for (int i = 1; i < 8; i++) beat(256'(i + 500));

    // Reset in the middle of a load.
    cycle(1'b1, 16'h00A0, 17'd1, 1'b0, 1'b0, 256'd0);
    for (int i = 0; i < 5; i++) beat(256'(i + 600));
    do_reset();
    cycle(1'b1, 16'h00B0, 17'd1, 1'b0, 1'b0, 256'd0);
    for (int i = 0; i < 8; i++) beat(256'(i + 700));
    chk("t6_done", done, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 3) == 0,
            ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
            17'($urandom_range(0, 3)),
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 9) < 7,
            rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_buffer_loader.md
Name: weight_buffer_loader

Overview:
- Upstream feeder for the weight buffer stage.
- Accepts one load command (start row address, row count), then consumes a 256-bit DDR beat stream with a valid/ready handshake.
- Turns each beat into a registered write strobe group (data_wr / wr_addr / wr_en) for the weight buffer's write port.
- Each beat fills one group of DDR_DATA_LEN/DATA_LEN buffers at one row. GROUP_NUM beats complete one row across all BUFFER_NUM buffers.

Parameters:
- X_PE, 16, PE count per mesh (sizing only)
- X_MESH, 16, mesh count (sizing only)
- ADDR_LEN, 16, buffer row address width
- DATA_LEN, 64, width of one buffer bank
- DDR_DATA_LEN, 256, DDR beat width
- BUFFER_NUM, 8*X_PE*X_MESH/DATA_LEN (=32), number of buffer banks
- BANKS_PER_BEAT, DDR_DATA_LEN/DATA_LEN (=4), banks written per beat
- GROUP_NUM, BUFFER_NUM/BANKS_PER_BEAT (=8), beats per row; must be a power of two

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  load command valid
- cfg_ready  out  1  high when IDLE; command accepted on cfg_valid&&cfg_ready
- cfg_st_addr  in  ADDR_LEN  first buffer row to write
- cfg_rows  in  ADDR_LEN+1  number of rows to load; 0 is legal
- abort  in  1  synchronous cancel of the current load
- ddr_data  in  DDR_DATA_LEN  weight beat
- ddr_valid  in  1  beat valid
- ddr_ready  out  1  beat accepted on ddr_valid&&ddr_ready
- data_wr  out  DDR_DATA_LEN  write data to the buffer
- wr_addr  out  ADDR_LEN  write row address to the buffer
- wr_en  out  BUFFER_NUM  per-bank write enables
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse when a load completes normally

Behaviour:
- Reset (async assert, sync release): state=IDLE; cfg_ready=1; ddr_ready=0; busy=0; done=0; wr_en=0; data_wr=0; wr_addr=0; internal grp=0, row_addr=0, rows_left=0.
- States: IDLE, LOAD. ddr_ready = (state==LOAD) && !abort, combinational from state.
- IDLE, command accepted:
  - cfg_rows==0: stay IDLE, done=1 next cycle, no writes.
  - Otherwise: row_addr<=cfg_st_addr, rows_left<=cfg_rows, grp<=0, state<=LOAD.
- LOAD, beat accepted at edge T; at T+1:
  - data_wr=ddr_data, wr_addr=row_addr.
  - wr_en has exactly bits [grp*BANKS_PER_BEAT +: BANKS_PER_BEAT] set.
  - Output latency is 1 cycle from acceptance.
- Cycles with no accepted beat: wr_en=0; data_wr and wr_addr hold their last values.
- Counter update per accepted beat:
  - grp increments.
  - When grp==GROUP_NUM-1: grp wraps to 0, row_addr increments modulo 2^ADDR_LEN (FFFF wraps to 0000, no error), rows_left decrements.
- Last beat (grp==GROUP_NUM-1 and rows_left==1):
  - state<=IDLE.
  - done=1 in the same cycle as the final wr_en.
  - cfg_ready=1 from that cycle; a new command may be accepted there, back-to-back.
- ddr_valid deasserted mid-row: counters hold; the load resumes with the next beat. No timeout.
- ddr_valid high while IDLE: ddr_ready=0, data is not consumed.
- cfg_valid while LOAD: ignored, because cfg_ready=0.
- abort:
  - In LOAD: no beat accepted that cycle; state<=IDLE, grp<=0, no done. Writes already issued stand; the partial row is not rolled back.
  - In IDLE: no effect. abort wins over a simultaneous cfg_valid, which is not accepted.
- rst_n asserted mid-load: everything returns to reset values immediately. wr_en drops asynchronously, so no spurious write.
- Exactly one group of bank enables may be set per cycle.

Test Plan:
- Load, no stalls: cfg_st_addr=0x0010, cfg_rows=2, continuous 16 beats with data=beat index.
  - Beats 0..7 → wr_addr=0x0010, wr_en=0x0000000F, 0x000000F0, … 0xF0000000.
  - Beats 8..15 → wr_addr=0x0011, same enable sequence.
  - done coincides with the 16th wr_en; cfg_ready=1 the same cycle.
- Backpressure: ddr_valid toggled 1,0,0,1 during row 0, cfg_rows=1.
  - Exactly 8 nonzero wr_en cycles; each write 1 cycle after its accept; no skipped or duplicated group.
- Wrap: cfg_st_addr=0xFFFF, cfg_rows=2 → rows written at 0xFFFF then 0x0000; done after 16 beats.
- Zero and back-to-back:
  - cfg_rows=0 → done next cycle, wr_en never set, ddr_ready stays 0.
  - Next, a cfg_rows=1 command issued in the done cycle → accepted; its 8 writes follow.
- Abort: abort asserted after 3 beats of cfg_rows=1 → exactly 3 writes (groups 0–2), no done, cfg_ready=1 next cycle. A new load then starts at group 0.
- Reset mid-load: rst_n pulled low after 5 beats → wr_en=0, busy=0, cfg_ready=1 immediately. After release, a full 1-row load completes normally.
